// File: rtl/reglist_sequencer_if.sv
// Bundle of decode, register-file and memory signals owned by the load/store-multiple sequencer.
// The master modport is the sequencer side; slave is the surrounding decode/regfile/memory side.
interface reglist_sequencer_if #(
    parameter int unsigned ADDR_W = 32
) ();
    // Operation request from decode
    logic              start;
    logic              load;
    logic              up;
    logic              pre;
    logic              writeback;
    logic [3:0]        rn;
    logic [15:0]       reglist;
    logic [ADDR_W-1:0] base;

    // Register file ports
    logic [ADDR_W-1:0] rf_rd1;
    logic [3:0]        rf_a1;
    logic [3:0]        rf_a3;
    logic [ADDR_W-1:0] rf_wd3;
    logic              rf_we3;
    logic              pc_we;
    logic [ADDR_W-1:0] pc_wd;

    // Memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_ready;

    // Status
    logic              busy;
    logic              done;

    modport master (
        input  start, load, up, pre, writeback, rn, reglist, base,
        input  rf_rd1, mem_rdata, mem_ready,
        output busy, done, rf_a1, rf_a3, rf_wd3, rf_we3, pc_we, pc_wd,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, load, up, pre, writeback, rn, reglist, base,
        output rf_rd1, mem_rdata, mem_ready,
        input  busy, done, rf_a1, rf_a3, rf_wd3, rf_we3, pc_we, pc_wd,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/reglist_sequencer.sv
// Load/store-multiple sequencer: one word transfer per set reglist bit, ascending register order.
// Base writeback (WB state) is compiled in only when REGLIST_SEQ_WRITEBACK_EN is defined.
module reglist_sequencer #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    reglist_sequencer_if.master seq_io
);

    typedef enum logic [2:0] {StIdle, StCalc, StXfer, StFlush, StWb, StDone} state_e;

    state_e state_q, state_d;

    logic              load_q, load_d;
    logic              up_q, up_d;
    logic              pre_q, pre_d;
    logic [3:0]        rn_q, rn_d;
    logic [15:0]       list_q, list_d;
    logic [15:0]       mask_q, mask_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] final_q, final_d;
    logic              pend_q, pend_d;
    logic [3:0]        pend_idx_q, pend_idx_d;
    logic [ADDR_W-1:0] pend_data_q, pend_data_d;

    logic [4:0]        n_regs;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] first_addr;
    logic [3:0]        cur_reg;
    logic [15:0]       mask_rest;
    logic              hs;
    logic              wb_go;

    function automatic logic [4:0] popcount16(logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [3:0] lowest_set(logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    assign n_regs    = popcount16(list_q);
    assign span      = ADDR_W'(n_regs) << 2;
    assign cur_reg   = lowest_set(mask_q);
    assign mask_rest = mask_q & (mask_q - 16'd1);
    assign hs        = (state_q == StXfer) && seq_io.mem_ready;

    // IA: base, IB: base+4, DA: base-4N+4, DB: base-4N
    always_comb begin
        unique case ({up_q, pre_q})
            2'b10:   first_addr = base_q;
            2'b11:   first_addr = base_q + ADDR_W'(4);
            2'b00:   first_addr = base_q - span + ADDR_W'(4);
            default: first_addr = base_q - span;
        endcase
    end

`ifdef REGLIST_SEQ_WRITEBACK_EN
    logic wb_q, wb_d;

    assign wb_d  = (state_q == StIdle && seq_io.start) ? seq_io.writeback : wb_q;
    // A loaded base register keeps the loaded value rather than the updated base.
    assign wb_go = wb_q && !(load_q && list_q[rn_q]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_q <= 1'b0;
        end else begin
            wb_q <= wb_d;
        end
    end
`else
    logic unused_writeback;

    assign unused_writeback = seq_io.writeback;
    assign wb_go            = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (seq_io.start) state_d = StCalc;
            StCalc:  state_d = (n_regs == 5'd0) ? StDone : StXfer;
            StXfer:  if (hs && (mask_rest == 16'd0)) state_d = StFlush;
            StFlush: state_d = wb_go ? StWb : StDone;
            StWb:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        seq_io.busy      = (state_q != StIdle);
        seq_io.done      = (state_q == StDone);
        seq_io.mem_req   = 1'b0;
        seq_io.mem_we    = 1'b0;
        seq_io.mem_addr  = '0;
        seq_io.mem_wdata = '0;
        seq_io.rf_a1     = '0;
        seq_io.rf_a3     = '0;
        seq_io.rf_wd3    = '0;
        seq_io.rf_we3    = 1'b0;
        seq_io.pc_we     = 1'b0;
        seq_io.pc_wd     = '0;

        if (state_q == StXfer) begin
            seq_io.mem_req  = 1'b1;
            seq_io.mem_we   = !load_q;
            seq_io.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            if (!load_q) begin
                seq_io.rf_a1     = cur_reg;
                seq_io.mem_wdata = seq_io.rf_rd1;
            end
        end

        // Pending load write and WB never coincide: WB follows the FLUSH that drains it.
        if (pend_q) begin
            if (pend_idx_q == 4'd15) begin
                seq_io.pc_we = 1'b1;
                seq_io.pc_wd = pend_data_q;
            end else begin
                seq_io.rf_we3 = 1'b1;
                seq_io.rf_a3  = pend_idx_q;
                seq_io.rf_wd3 = pend_data_q;
            end
        end else if (state_q == StWb) begin
            if (rn_q == 4'd15) begin
                seq_io.pc_we = 1'b1;
                seq_io.pc_wd = final_q;
            end else begin
                seq_io.rf_we3 = 1'b1;
                seq_io.rf_a3  = rn_q;
                seq_io.rf_wd3 = final_q;
            end
        end
    end

    always_comb begin
        load_d      = load_q;
        up_d        = up_q;
        pre_d       = pre_q;
        rn_d        = rn_q;
        list_d      = list_q;
        mask_d      = mask_q;
        base_d      = base_q;
        addr_d      = addr_q;
        final_d     = final_q;
        pend_d      = 1'b0;
        pend_idx_d  = pend_idx_q;
        pend_data_d = pend_data_q;

        unique case (state_q)
            StIdle: begin
                if (seq_io.start) begin
                    load_d = seq_io.load;
                    up_d   = seq_io.up;
                    pre_d  = seq_io.pre;
                    rn_d   = seq_io.rn;
                    list_d = seq_io.reglist;
                    mask_d = seq_io.reglist;
                    base_d = seq_io.base;
                end
            end
            StCalc: begin
                addr_d  = first_addr;
                final_d = up_q ? (base_q + span) : (base_q - span);
            end
            StXfer: begin
                if (hs) begin
                    mask_d = mask_rest;
                    addr_d = addr_q + ADDR_W'(4);
                    if (load_q) begin
                        pend_d      = 1'b1;
                        pend_idx_d  = cur_reg;
                        pend_data_d = seq_io.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            load_q      <= 1'b0;
            up_q        <= 1'b0;
            pre_q       <= 1'b0;
            rn_q        <= '0;
            list_q      <= '0;
            mask_q      <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            final_q     <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            pend_data_q <= '0;
        end else begin
            load_q      <= load_d;
            up_q        <= up_d;
            pre_q       <= pre_d;
            rn_q        <= rn_d;
            list_q      <= list_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            final_q     <= final_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            pend_data_q <= pend_data_d;
        end
    end

endmodule

// File: tb/tb_reglist_sequencer.sv
// Scoreboard bench for reglist_sequencer: directed operations push expected transfers, register
// writes and done timing into queues; a negedge monitor pops and compares on every DUT event.
module tb_reglist_sequencer;

    localparam int unsigned AW = 32;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  a1;
    } mem_t;

    typedef struct {
        logic [3:0]  a3;
        logic [31:0] wd;
    } rfw_t;

    logic clk;
    logic rst;
    int   cyc;
    int   t0;
    int   n_checks;
    int   n_fail;
    int   hs_cnt;
    logic done_seen;

    mem_t        exp_mem[$];
    rfw_t        exp_rf[$];
    logic [31:0] exp_pc[$];
    int          exp_done[$];

    reglist_sequencer_if #(.ADDR_W(AW)) bus ();

    reglist_sequencer #(.ADDR_W(AW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .seq_io (bus)
    );

    // Memory returns address-tagged data; register file returns index-tagged data.
    assign bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_0000;
    assign bus.rf_rd1    = {28'hBEEF000, bus.rf_a1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_%s: got event with value 0x%08h, required none", name, act);
    endtask

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] a1);
        mem_t m;
        m.addr = a; m.we = we; m.wdata = wd; m.a1 = a1;
        exp_mem.push_back(m);
    endtask

    task automatic push_rf(input logic [3:0] a3, input logic [31:0] wd);
        rfw_t r;
        r.a3 = a3; r.wd = wd;
        exp_rf.push_back(r);
    endtask

    task automatic push_wb_rf(input logic [3:0] a3, input logic [31:0] wd);
`ifdef REGLIST_SEQ_WRITEBACK_EN
        push_rf(a3, wd);
`else
        if (a3 == 4'hx && wd == 32'hx) push_rf(a3, wd);
`endif
    endtask

    task automatic push_wb_pc(input logic [31:0] wd);
`ifdef REGLIST_SEQ_WRITEBACK_EN
        exp_pc.push_back(wd);
`else
        if (wd == 32'hx) exp_pc.push_back(wd);
`endif
    endtask

    task automatic push_done(input int no_wb, input int with_wb);
`ifdef REGLIST_SEQ_WRITEBACK_EN
        exp_done.push_back(with_wb);
`else
        exp_done.push_back(no_wb);
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_mem_req"}, {31'b0, bus.mem_req}, 32'd0);
        check({tag, "_mem_we"}, {31'b0, bus.mem_we}, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_rf_a1"}, {28'b0, bus.rf_a1}, 32'd0);
        check({tag, "_rf_we3"}, {31'b0, bus.rf_we3}, 32'd0);
        check({tag, "_rf_a3"}, {28'b0, bus.rf_a3}, 32'd0);
        check({tag, "_rf_wd3"}, bus.rf_wd3, 32'd0);
        check({tag, "_pc_we"}, {31'b0, bus.pc_we}, 32'd0);
        check({tag, "_pc_wd"}, bus.pc_wd, 32'd0);
    endtask

    // Monitor: compares every handshake, register write and done pulse against the queues.
    initial begin
        logic        stalled;
        logic [31:0] st_addr;
        logic [31:0] st_wdata;
        logic        st_we;
        mem_t        m;
        rfw_t        r;
        logic [31:0] p;
        int          d;
        stalled = 1'b0;
        st_addr = '0;
        st_wdata = '0;
        st_we = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled && !rst) begin
                check("hold_mem_req", {31'b0, bus.mem_req}, 32'd1);
                check("hold_mem_addr", bus.mem_addr, st_addr);
                check("hold_mem_wdata", bus.mem_wdata, st_wdata);
                check("hold_mem_we", {31'b0, bus.mem_we}, {31'b0, st_we});
            end
            stalled  = bus.mem_req && !bus.mem_ready;
            st_addr  = bus.mem_addr;
            st_wdata = bus.mem_wdata;
            st_we    = bus.mem_we;
            if (bus.mem_req && bus.mem_ready) begin
                hs_cnt++;
                if (exp_mem.size() == 0) begin
                    unexpected("mem_req", bus.mem_addr);
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_addr", bus.mem_addr, m.addr);
                    check("mem_we", {31'b0, bus.mem_we}, {31'b0, m.we});
                    if (m.we) begin
                        check("mem_wdata", bus.mem_wdata, m.wdata);
                        check("rf_a1", {28'b0, bus.rf_a1}, {28'b0, m.a1});
                    end
                end
            end
            if (bus.rf_we3) begin
                check("rf_a3_not_15", {31'b0, bus.rf_a3 == 4'd15}, 32'd0);
                check("single_write_port", {31'b0, bus.pc_we}, 32'd0);
                if (exp_rf.size() == 0) begin
                    unexpected("rf_we3", {28'b0, bus.rf_a3});
                end else begin
                    r = exp_rf.pop_front();
                    check("rf_a3", {28'b0, bus.rf_a3}, {28'b0, r.a3});
                    check("rf_wd3", bus.rf_wd3, r.wd);
                end
            end
            if (bus.pc_we) begin
                if (exp_pc.size() == 0) begin
                    unexpected("pc_we", bus.pc_wd);
                end else begin
                    p = exp_pc.pop_front();
                    check("pc_wd", bus.pc_wd, p);
                end
            end
            if (bus.done) begin
                done_seen = 1'b1;
                if (exp_done.size() == 0) begin
                    unexpected("done", 32'(cyc - t0 + 1));
                end else begin
                    d = exp_done.pop_front();
                    check("done_cycle", 32'(cyc - t0 + 1), 32'(d));
                end
            end
        end
    end

    // Issues one operation; called at posedge+1. rst_at > 0 asserts reset in that cycle.
    task automatic run_op(input logic ld, input logic u, input logic p, input logic wb,
                          input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base,
                          input int stall_idx, input int stall_len, input int rst_at);
        int stalls;
        stalls        = 0;
        done_seen     = 1'b0;
        hs_cnt        = 0;
        bus.start     = 1'b1;
        bus.load      = ld;
        bus.up        = u;
        bus.pre       = p;
        bus.writeback = wb;
        bus.rn        = rn;
        bus.reglist   = list;
        bus.base      = base;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        // Scramble operands to show they were latched at start.
        bus.start     = 1'b0;
        bus.load      = !ld;
        bus.up        = !u;
        bus.pre       = !p;
        bus.writeback = !wb;
        bus.rn        = ~rn;
        bus.reglist   = 16'hFFFF;
        bus.base      = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40 && !done_seen; k++) begin
            if (bus.mem_req && hs_cnt == stall_idx && stalls < stall_len) begin
                bus.mem_ready = 1'b0;
                stalls++;
            end else begin
                bus.mem_ready = 1'b1;
            end
            if (k == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            if (k == rst_at) begin
                rst = 1'b0;
                check_idle("mid_reset");
                repeat (6) @(posedge clk);
                #1;
                break;
            end
        end
        if (rst_at == 0) begin
            check("done_seen", {31'b0, done_seen}, 32'd1);
        end
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("drain_mem", 32'(exp_mem.size()), 32'd0);
        check("drain_rf", 32'(exp_rf.size()), 32'd0);
        check("drain_pc", 32'(exp_pc.size()), 32'd0);
        check("drain_done", 32'(exp_done.size()), 32'd0);
        exp_mem.delete();
        exp_rf.delete();
        exp_pc.delete();
        exp_done.delete();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        hs_cnt        = 0;
        done_seen     = 1'b0;
        t0            = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.load      = 1'b0;
        bus.up        = 1'b0;
        bus.pre       = 1'b0;
        bus.writeback = 1'b0;
        bus.rn        = '0;
        bus.reglist   = '0;
        bus.base      = '0;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // LDMIA base 0x100 {R1,R2}, writeback R0
        push_mem(32'h100, 1'b0, '0, '0);
        push_mem(32'h104, 1'b0, '0, '0);
        push_rf(4'd1, 32'hA5A5_0100);
        push_rf(4'd2, 32'hA5A5_0104);
        push_wb_rf(4'd0, 32'h108);
        push_done(5, 6);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0006, 32'h100, -1, 0, 0);

        // STMDB base 0x200 {R4,R14}, writeback R13
        push_mem(32'h1F8, 1'b1, 32'hBEEF_0004, 4'd4);
        push_mem(32'h1FC, 1'b1, 32'hBEEF_000E, 4'd14);
        push_wb_rf(4'd13, 32'h1F8);
        push_done(5, 6);
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h4010, 32'h200, -1, 0, 0);

        // LDMIA base 0x40 {R0,R15}: R15 via pc port
        push_mem(32'h40, 1'b0, '0, '0);
        push_mem(32'h44, 1'b0, '0, '0);
        push_rf(4'd0, 32'hA5A5_0040);
        exp_pc.push_back(32'hA5A5_0044);
        push_done(5, 5);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 16'h8001, 32'h40, -1, 0, 0);

        // Empty list: no transfers, no writeback, done in cycle 2
        push_done(2, 2);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 16'h0000, 32'h500, -1, 0, 0);

        // STMIA with 3 wait states on the second transfer
        push_mem(32'h300, 1'b1, 32'hBEEF_0000, 4'd0);
        push_mem(32'h304, 1'b1, 32'hBEEF_0001, 4'd1);
        push_mem(32'h308, 1'b1, 32'hBEEF_0002, 4'd2);
        push_done(9, 9);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0007, 32'h300, 1, 3, 0);

        // LDMIB with base register in list: writeback suppressed
        push_mem(32'h1004, 1'b0, '0, '0);
        push_mem(32'h1008, 1'b0, '0, '0);
        push_rf(4'd0, 32'hA5A5_1004);
        push_rf(4'd5, 32'hA5A5_1008);
        push_done(5, 5);
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 16'h0021, 32'h1000, -1, 0, 0);

        // STMDA base 0x10 {R0,R1}, writeback to R15
        push_mem(32'hC, 1'b1, 32'hBEEF_0000, 4'd0);
        push_mem(32'h10, 1'b1, 32'hBEEF_0001, 4'd1);
        push_wb_pc(32'h8);
        push_done(5, 6);
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 16'h0003, 32'h10, -1, 0, 0);

        // LDMDB base 0x4 {R0,R1}: address wraps through zero
        push_mem(32'hFFFF_FFFC, 1'b0, '0, '0);
        push_mem(32'h0, 1'b0, '0, '0);
        push_rf(4'd0, 32'h5A5A_FFFC);
        push_rf(4'd1, 32'hA5A5_0000);
        push_done(5, 5);
        run_op(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0003, 32'h4, -1, 0, 0);

        // Unaligned base: address low bits forced to zero, final base keeps them
        push_mem(32'h100, 1'b0, '0, '0);
        push_rf(4'd0, 32'hA5A5_0100);
        push_wb_rf(4'd2, 32'h107);
        push_done(4, 5);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0001, 32'h103, -1, 0, 0);

        // Reset during the first handshake: nothing after it
        push_mem(32'h100, 1'b0, '0, '0);
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h0006, 32'h100, -1, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reglist_sequencer.md
# reglist_sequencer

Multi-cycle load/store-multiple sequencer for the 16-entry register file. It walks a 16-bit register list and issues one word memory transfer per set bit in ascending register order. Loads write the register file write port; stores drive read port 1. Base writeback is optional. The block sits between decode and the register file/memory ports and owns those ports while `busy` is high.

## Interface
- `ADDR_W`, 32, address/data width; fixed at 32, other values unsupported.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: begin operation; sampled only in IDLE.
- `load` in 1: 1 = LDM, 0 = STM; latched at start.
- `up` / `pre` in 1 / 1: increment vs decrement, before vs after; latched.
- `writeback` in 1: write final base to `rn`; latched.
- `rn` in 4: base register index; latched.
- `reglist` in 16: bit i set transfers Ri; latched.
- `base` in 32: base address value; latched.
- `rf_rd1` in 32: register file RD1, combinational.
- `mem_rdata` in 32: load data, valid when `mem_ready`.
- `mem_ready` in 1: completes the current request this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `rf_a1` out 4: read address for STM.
- `rf_a3` / `rf_wd3` / `rf_we3` out 4/32/1: register file write port.
- `pc_we` / `pc_wd` out 1/32: R15 load; R15 is never written through `rf_we3`.
- `mem_req` / `mem_we` / `mem_addr` / `mem_wdata` out 1/1/32/32: memory request.

## Operation
- States: IDLE, CALC, XFER, FLUSH, WB, DONE.
- IDLE: when `start`=1, latch all operands and go to CALC.
- CALC: compute N = popcount(reglist) and the first address.
  - IA: first address = base. IB: base+4. DA: base−4N+4. DB: base−4N.
  - Final base = base ± 4N.
  - If N=0, go directly to DONE: no transfers and no writeback.
  - Otherwise go to XFER.
- XFER:
  - Current register = lowest set bit of the remaining mask.
  - `mem_req`=1, `mem_we`=!load, `mem_addr` = current address with bits [1:0] forced to 0.
  - For STM, `rf_a1` = current register and `mem_wdata` = `rf_rd1` (passthrough).
  - A handshake is a cycle with `mem_req`&&`mem_ready`. On a handshake: clear the mask bit, add 4 to the address, and for LDM capture `mem_rdata` and the register index.
  - When the mask empties, go to FLUSH.
- Captured load data is written in the cycle after its handshake.
  - Index 15: `pc_we`=1, `pc_wd` = data.
  - Otherwise: `rf_we3`=1, `rf_a3` = index, `rf_wd3` = data.
  - This write can overlap the next XFER request.
- FLUSH: performs the last pending load write (idle cycle for STM). Next state is WB if writeback is enabled and not (load && reglist[rn]); otherwise DONE.
- WB: `rf_we3`=1, `rf_a3`=rn, `rf_wd3` = final base. If rn=15, use `pc_we`/`pc_wd` instead. Then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while busy is ignored.
- All address arithmetic is modulo 2^32; wrap-around is legal and unflagged.

## Timing
- Reset value of every output is 0; state returns to IDLE.
- RST mid-operation aborts at the next edge. Pending load writes and writeback are dropped, and no `done` is issued.
- Start sampled at edge 0. CALC is cycle 1. The first `mem_req` is in cycle 2.
- Zero wait states: N transfers take N XFER cycles.
- Total with no writeback: start to `done` = 3+N cycles. Writeback adds 1 cycle. N=0 gives `done` in cycle 2.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1 and `mem_ready`=0.
- `mem_req` is never dropped before a handshake.
- At most one of `rf_we3` and `pc_we` is asserted per cycle.
- Register writes land at the clock edge ending the cycle in which they are asserted.

## Configuration
- `REGLIST_SEQ_WRITEBACK_EN` defined: writeback input honoured; WB state present.
- Not defined:
  - `writeback` is ignored and WB is unreachable.
  - FLUSH always goes to DONE.
  - Total latency is always 3+N.

## Test plan
- LDMIA, base=0x100, reglist=0x0006, rn=0, writeback=1, ready always 1:
  - Addresses 0x100 then 0x104.
  - `rf_we3` writes R1 then R2.
  - Then R0=0x108.
  - `done` in cycle 6.
- STMDB, base=0x200, reglist=0x4010, writeback=1, rn=13:
  - Addresses 0x1F8 (`rf_a1`=4), then 0x1FC (`rf_a1`=14).
  - `mem_we`=1.
  - R13=0x1F8 written in WB.
- LDMIA, reglist=0x8001, base=0x40:
  - R0 ← data@0x40.
  - `pc_we`=1 with `pc_wd` = data@0x44.
  - `rf_we3` never asserted with `rf_a3`=15.
- reglist=0x0000, start=1:
  - `mem_req` never asserted.
  - `done` pulses in cycle 2.
  - `rf_we3`=0 throughout.
- `mem_ready` held low 3 cycles on the second transfer:
  - `mem_addr` and `mem_wdata` held constant.
  - `done` delayed exactly 3 cycles.
- RST asserted in the cycle of the first handshake:
  - Next cycle: all outputs 0 and state IDLE.
  - No register write and no `done`.
